conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
Frame-level controller in front of the feature_buf -> conv -> post_processing chain. It accepts one image frame of IMG_W x IMG_H 8-bit pixels from an upstream source under a valid/ready handshake. It forwards the pixels into the convolution path, honouring the conv line-buffer backpressure (hold), then counts conv output vectors until the frame's full output map has been produced. It reports completion, progress and a drain-timeout error.

Parameters:
IMG_W, 32, input frame width in pixels
IMG_H, 32, input frame height in pixels
KERNEL, 5, conv kernel size; the output map is (IMG_W-KERNEL+1) x (IMG_H-KERNEL+1)
DRAIN_TIMEOUT, 1024, max cycles allowed between conv output valids while in DRAIN
CNT_W, 10, width of out_count; must hold (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
pix_in  in  8  upstream pixel
pix_in_valid  in  1  upstream pixel valid
pix_in_ready  out  1  sequencer can accept a pixel this cycle
hold  in  1  conv line buffer full (o_buffer_full); stalls pixel acceptance
conv_valid  in  1  conv output feature vector valid (o_feature_valid)
feat_out  out  8  pixel to the conv input path
feat_out_valid  out  1  feat_out valid
busy  out  1  high in LOAD and DRAIN
frame_done  out  1  one-cycle pulse at end of frame
out_count  out  CNT_W  conv output vectors counted in the current frame
timeout_err  out  1  sticky; set when DRAIN times out, cleared on the next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE. feat_out=0, feat_out_valid=0, pix_in_ready=0, busy=0, frame_done=0, out_count=0, timeout_err=0. Column, row and timeout counters are cleared. Reset asserted mid-frame aborts the frame. No frame_done is issued for it.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: pix_in_ready=0. When start=1, go to LOAD on the next cycle. On that start, clear the column/row counters, out_count and timeout_err. conv_valid is ignored in IDLE.
- LOAD:
  - pix_in_ready = !hold (combinational).
  - A transfer occurs when pix_in_valid & pix_in_ready.
  - On a transfer, feat_out <= pix_in and feat_out_valid <= 1 on the next edge, giving 1-cycle latency. feat_out_valid is 0 on any cycle after a non-transfer cycle. feat_out holds its last value when not valid.
  - Column counter 0..IMG_W-1 increments per transfer. On wrap it returns to 0 and the row counter increments.
  - The transfer at column IMG_W-1, row IMG_H-1 moves the state to DRAIN.
  - hold and pix_in_valid are independent. With hold=1, no transfer happens even if valid is high.
- conv_valid pulses in LOAD or DRAIN increment out_count, saturating at the expected total (OUT_W*OUT_H).
- DRAIN:
  - pix_in_ready=0.
  - The timeout counter increments every cycle and resets to 0 on each conv_valid.
  - When out_count reaches the expected total, go to DONE.
  - If the timeout counter reaches DRAIN_TIMEOUT first, set timeout_err and go to DONE.
  - If conv_valid arrives on the same cycle the timeout counter reaches DRAIN_TIMEOUT, the count wins and no error is set.
- DONE: frame_done=1 for exactly this one cycle, then IDLE. out_count holds its value until the next accepted start.
- busy=1 exactly in LOAD and DRAIN.
- start outside IDLE (including DONE) is ignored.
- Expected total with defaults: 28*28 = 784 (fits CNT_W=10).
- All state and outputs are registered except pix_in_ready.

Test Plan:
- Reset then idle: with rst=0, then rst=1 and no start, all outputs stay 0 for 20 cycles. pix_in_valid=1 with pix_in=0xAA -> pix_in_ready=0 and feat_out_valid=0.
- Nominal frame (IMG_W=8, IMG_H=8, KERNEL=3): pulse start, stream pixels 0..63 back-to-back with hold=0, then give 36 conv_valid pulses in DRAIN -> feat_out equals 0..63 with 1-cycle latency, busy high for the whole frame, out_count=36, a single frame_done pulse, timeout_err=0.
- Backpressure: hold=1 for cycles 10-14 of LOAD with pix_in_valid held high -> pix_in_ready=0 and no transfers in that window. Pixel order is preserved, no pixel is duplicated or dropped, and 64 transfers complete in total.
- Drain timeout (DRAIN_TIMEOUT=16): provide only 30 of the 36 conv_valid pulses -> 16 idle cycles after the last pulse, timeout_err=1, frame_done pulses, out_count=30. The next start clears timeout_err and out_count.
- Boundary/simultaneous: conv_valid on the same cycle the timeout counter hits the limit -> no error. A start pulse during LOAD and in DONE is ignored. Extra conv_valid pulses after 36 leave out_count at 36.
- Reset mid-frame: drive rst=0 after 20 pixels -> outputs clear immediately (async) with no frame_done. A new start after release runs a full 64-pixel frame correctly.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_sequencer
// Brief    : Accepts one IMG_W x IMG_H pixel frame, forwards it into the conv
//            path and counts conv output vectors until the output map is done.
// Revision : 1.0
// ============================================================================
module conv_frame_sequencer #(
   parameter int IMG_W         = 32,
   parameter int IMG_H         = 32,
   parameter int KERNEL        = 5,
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int CNT_W         = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       pix_in,
   input  logic             pix_in_valid,
   output logic             pix_in_ready,
   input  logic             hold,
   input  logic             conv_valid,
   output logic [7:0]       feat_out,
   output logic             feat_out_valid,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] out_count,
   output logic             timeout_err
);

   localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int c_tmo_w = $clog2(DRAIN_TIMEOUT + 1);

   localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_W - 1);
   localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(IMG_H - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0]   c_total     =
      CNT_W'((IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_col_w-1:0]   r_col;
   logic [c_row_w-1:0]   r_row;
   logic [c_tmo_w-1:0]   r_tmo;

   logic                 w_xfer;
   logic                 w_cnt_inc;
   logic [CNT_W-1:0]     w_count_next;
   logic [c_tmo_w-1:0]   w_tmo_next;

   always_comb begin
      pix_in_ready = (r_state == S_LOAD) && !hold;
      w_xfer       = pix_in_valid && pix_in_ready;
      // conv outputs only count while a frame is in flight, saturating at the map size
      w_cnt_inc    = conv_valid && ((r_state == S_LOAD) || (r_state == S_DRAIN))
                     && (out_count != c_total);
      w_count_next = out_count + CNT_W'(w_cnt_inc);
      w_tmo_next   = r_tmo + c_tmo_w'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_col          <= '0;
         r_row          <= '0;
         r_tmo          <= '0;
         feat_out       <= '0;
         feat_out_valid <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         out_count      <= '0;
         timeout_err    <= 1'b0;
      end else begin
         feat_out_valid <= 1'b0;
         frame_done     <= 1'b0;
         out_count      <= w_count_next;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_LOAD;
                  busy        <= 1'b1;
                  r_col       <= '0;
                  r_row       <= '0;
                  r_tmo       <= '0;
                  out_count   <= '0;
                  timeout_err <= 1'b0;
               end
            end

            S_LOAD: begin
               if (w_xfer) begin
                  feat_out       <= pix_in;
                  feat_out_valid <= 1'b1;
                  if (r_col == c_col_last) begin
                     r_col <= '0;
                     if (r_row == c_row_last) begin
                        r_row   <= '0;
                        r_state <= S_DRAIN;
                     end else begin
                        r_row <= r_row + c_row_w'(1);
                     end
                  end else begin
                     r_col <= r_col + c_col_w'(1);
                  end
               end
            end

            S_DRAIN: begin
               r_tmo <= conv_valid ? '0 : w_tmo_next;
               // a conv_valid landing on the limit cycle restarts the window, so completion wins
               if (w_count_next == c_total) begin
                  r_state    <= S_DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else if (!conv_valid && (w_tmo_next == c_tmo_limit)) begin
                  r_state     <= S_DONE;
                  busy        <= 1'b0;
                  frame_done  <= 1'b1;
                  timeout_err <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_sequencer
// Brief    : Randomised and directed frames checked against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_conv_frame_sequencer;

   localparam int IMG_W         = 8;
   localparam int IMG_H         = 8;
   localparam int KERNEL        = 3;
   localparam int DRAIN_TIMEOUT = 16;
   localparam int CNT_W         = 10;
   localparam int c_npix        = IMG_W * IMG_H;
   localparam int c_total       = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);

   logic             clk          = 1'b0;
   logic             rst          = 1'b1;
   logic             start        = 1'b0;
   logic [7:0]       pix_in       = 8'h00;
   logic             pix_in_valid = 1'b0;
   logic             hold         = 1'b0;
   logic             conv_valid   = 1'b0;
   logic             pix_in_ready;
   logic [7:0]       feat_out;
   logic             feat_out_valid;
   logic             busy;
   logic             frame_done;
   logic [CNT_W-1:0] out_count;
   logic             timeout_err;

   conv_frame_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL),
      .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
      .hold(hold), .conv_valid(conv_valid),
      .feat_out(feat_out), .feat_out_valid(feat_out_valid),
      .busy(busy), .frame_done(frame_done),
      .out_count(out_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   logic [7:0] got_q[$];
   logic [7:0] sent[c_npix];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is active from start until its pixels are in and
   // either the output map is complete or the drain goes quiet for too long.
   int         m_active, m_pix, m_cnt, m_idle;
   bit         m_done, m_err, m_fv;
   logic [7:0] m_fo;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 0; m_pix = 0; m_cnt = 0; m_idle = 0;
         m_done = 0; m_err = 0; m_fv = 0; m_fo = 8'h00;
      end else begin
         m_fv = 0;
         if (m_done) begin
            m_done = 0;
         end else if (m_active == 0) begin
            if (start) begin
               m_active = 1; m_pix = 0; m_cnt = 0; m_idle = 0; m_err = 0;
            end
         end else begin
            if (conv_valid && m_cnt < c_total) m_cnt++;
            if (m_pix < c_npix) begin
               if (pix_in_valid && !hold) begin
                  m_fv = 1; m_fo = pix_in; m_pix++;
               end
            end else begin
               m_idle = conv_valid ? 0 : m_idle + 1;
               if (m_cnt == c_total || m_idle == DRAIN_TIMEOUT) begin
                  m_err    = (m_cnt != c_total);
                  m_active = 0;
                  m_done   = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("busy",           32'(busy),           32'(m_active != 0));
         chk("frame_done",     32'(frame_done),     32'(m_done));
         chk("out_count",      32'(out_count),      32'(m_cnt));
         chk("timeout_err",    32'(timeout_err),    32'(m_err));
         chk("feat_out_valid", 32'(feat_out_valid), 32'(m_fv));
         chk("feat_out",       32'(feat_out),       32'(m_fo));
         chk("pix_in_ready",   32'(pix_in_ready),
             32'((m_active != 0) && (m_pix < c_npix) && !hold));
         if (frame_done) n_done++;
         if (feat_out_valid) got_q.push_back(feat_out);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // gap >= 0: fixed idle cycles before each drain pulse; gap < 0: random 0..-gap
   task automatic run_frame(input bit rnd, input int n_conv, input int gap,
                            input bit hold_win, input bit extra_start, input int abort_at);
      int idx, cyc, d0, g;
      bit acc, ok;
      got_q.delete();
      d0 = n_done;
      for (int i = 0; i < c_npix; i++) sent[i] = rnd ? 8'($urandom) : 8'(i);
      start = 1'b1; conv_valid = 1'b0;
      step();
      start = 1'b0;
      chk("start_clears_err", 32'(timeout_err), 32'd0);
      chk("start_clears_cnt", 32'(out_count), 32'd0);
      idx = 0; cyc = 0;
      while (idx < c_npix && cyc < 4000) begin
         if (abort_at > 0 && idx == abort_at) begin
            #2 rst = 1'b0;
            #1;
            chk("abort_busy",      32'(busy),           32'd0);
            chk("abort_fv",        32'(feat_out_valid), 32'd0);
            chk("abort_feat_out",  32'(feat_out),       32'd0);
            chk("abort_ready",     32'(pix_in_ready),   32'd0);
            pix_in_valid = 1'b0; hold = 1'b0; conv_valid = 1'b0;
            step(); step();
            rst = 1'b1;
            repeat (4) step();
            chk("abort_no_done", 32'(n_done - d0), 32'd0);
            return;
         end
         pix_in       = sent[idx];
         pix_in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         hold         = hold_win ? (cyc >= 10 && cyc <= 14)
                                 : (rnd ? ($urandom_range(0, 4) == 0) : 1'b0);
         conv_valid   = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
         start        = extra_start && (cyc == 20);
         #3;
         acc = pix_in_valid && pix_in_ready;
         if (hold_win && cyc >= 10 && cyc <= 14)
            chk("hold_blocks_ready", 32'(pix_in_ready), 32'd0);
         step();
         if (acc) idx++;
         cyc++;
      end
      chk("load_complete", 32'(idx), 32'(c_npix));
      pix_in_valid = 1'b0; hold = 1'b0; start = 1'b0; conv_valid = 1'b0;
      for (int p = 0; p < n_conv; p++) begin
         g = (gap < 0) ? int'($urandom_range(0, -gap)) : gap;
         repeat (g) begin
            conv_valid = 1'b0;
            start = extra_start && frame_done;
            step();
         end
         conv_valid = 1'b1;
         start = extra_start && frame_done;
         step();
      end
      conv_valid = 1'b0;
      for (int w = 0; w < 3 * DRAIN_TIMEOUT && n_done == d0; w++) begin
         start = extra_start && frame_done;
         step();
      end
      start = 1'b0;
      step();
      chk("done_pulses", 32'(n_done - d0), 32'd1);
      chk("pix_count",   32'(got_q.size()), 32'(c_npix));
      ok = (got_q.size() == c_npix);
      for (int i = 0; i < c_npix && ok; i++) if (got_q[i] !== sent[i]) ok = 0;
      chk("pix_order", 32'(ok), 32'd1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1);
   end

   initial begin
      #2 rst = 1'b0;
      #5;
      chk("rst_busy",        32'(busy),           32'd0);
      chk("rst_fv",          32'(feat_out_valid), 32'd0);
      chk("rst_done",        32'(frame_done),     32'd0);
      chk("rst_count",       32'(out_count),      32'd0);
      chk("rst_err",         32'(timeout_err),    32'd0);
      chk("rst_ready",       32'(pix_in_ready),   32'd0);
      repeat (2) step();
      rst = 1'b1;
      pix_in = 8'hAA; pix_in_valid = 1'b1;
      repeat (20) begin
         step();
         chk("idle_ready", 32'(pix_in_ready),   32'd0);
         chk("idle_fv",    32'(feat_out_valid), 32'd0);
         chk("idle_busy",  32'(busy),           32'd0);
      end
      pix_in_valid = 1'b0;

      run_frame(1'b0, 36, 0, 1'b0, 1'b0, 0);
      chk("nominal_count", 32'(out_count), 32'd36);
      chk("nominal_err",   32'(timeout_err), 32'd0);

      run_frame(1'b0, 36, 0, 1'b1, 1'b0, 0);
      chk("backpressure_count", 32'(out_count), 32'd36);

      run_frame(1'b0, 30, 0, 1'b0, 1'b0, 0);
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      chk("timeout_count",   32'(out_count),   32'd30);

      run_frame(1'b0, 36, DRAIN_TIMEOUT - 1, 1'b0, 1'b1, 0);
      chk("limit_edge_err",   32'(timeout_err), 32'd0);
      chk("limit_edge_count", 32'(out_count),   32'd36);

      run_frame(1'b0, 40, 0, 1'b0, 1'b0, 0);
      chk("saturate_count", 32'(out_count), 32'd36);

      run_frame(1'b0, 0, 0, 1'b0, 1'b0, 20);
      run_frame(1'b0, 36, 0, 1'b0, 1'b0, 0);
      chk("after_abort_count", 32'(out_count), 32'd36);

      repeat (8) begin
         run_frame(1'b1, int'($urandom_range(0, 40)), -int'($urandom_range(0, 20)),
                   1'b0, 1'($urandom_range(0, 1)), 0);
      end

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
